// File: rtl/nvram_upload_ctrl_if.sv
// nvram_upload_ctrl_if: HPS ioctl upload bus between hps_io (master) and the NVRAM upload controller (slave)
interface nvram_upload_ctrl_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait, ioctl_upload_req
  );
  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait, ioctl_upload_req
  );
endinterface

// File: rtl/nvram_upload_ctrl.sv
// nvram_upload_ctrl: serves HPS NVRAM uploads by pausing the CPU and reading bytes from the dump port
module nvram_upload_ctrl #(
  parameter int DUMPWIDTH = 10,
  parameter int DUMPINDEX = 4,
  parameter int READ_LAT  = 2,
  parameter int PAUSEPAD  = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  nvram_upload_ctrl_if.slave   io,
  input  logic                 osd_status,
  input  logic                 autosave,
  input  logic                 paused,
  output logic                 pause_cpu,
  output logic [DUMPWIDTH-1:0] ram_addr,
  input  logic [7:0]           ram_data,
  output logic                 busy
);
  typedef enum logic [2:0] {IDLE, PAUSE, SETTLE, READY, FETCH, DONE} state_t;
  localparam logic [7:0] PAD_LAST = 8'(PAUSEPAD - 1);
  localparam logic [7:0] LAT_LAST = 8'(READ_LAT - 1);
  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d, din_q, din_d;
  logic [24:0]          pend_addr_q, pend_addr_d, rd_addr;
  logic [DUMPWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                 pend_q, pend_d, oor_q, oor_d, end_q, end_d, osd_q;
  logic                 wait_q, wait_d, req_q, req_d, pause_q, busy_q;
  logic                 rd_go, rd_oor;
  // A live strobe in READY takes precedence over a read parked during PAUSE/SETTLE
  assign rd_go   = io.ioctl_rd | pend_q;
  assign rd_addr = io.ioctl_rd ? io.ioctl_addr : pend_addr_q;
  assign rd_oor  = |(rd_addr >> DUMPWIDTH);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 8'd1;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    oor_d       = oor_q;
    end_d       = end_q;
    din_d       = din_q;
    ram_addr_d  = ram_addr_q;
    if ((state_q == PAUSE || state_q == SETTLE) && io.ioctl_rd) begin
      pend_d      = 1'b1;
      pend_addr_d = io.ioctl_addr;
    end
    case (state_q)
      IDLE:    state_d = (io.ioctl_upload && io.ioctl_index == 8'(DUMPINDEX)) ? PAUSE : IDLE;
      PAUSE:   state_d = !io.ioctl_upload ? DONE : paused ? SETTLE : PAUSE;
      SETTLE:  state_d = !io.ioctl_upload ? DONE : (cnt_q == PAD_LAST) ? READY : SETTLE;
      READY:
        if (!io.ioctl_upload) state_d = DONE;
        else if (rd_go) begin
          state_d = FETCH;
          pend_d  = 1'b0;
          oor_d   = rd_oor;
          if (!rd_oor) ram_addr_d = rd_addr[DUMPWIDTH-1:0];
        end
      FETCH: begin
        end_d = end_q | ~io.ioctl_upload;
        if (cnt_q == LAT_LAST) begin
          din_d   = oor_q ? 8'h00 : ram_data;
          state_d = end_d ? DONE : READY;
          end_d   = 1'b0;
        end
      end
      DONE: begin
        pend_d  = 1'b0;
        state_d = (cnt_q == PAD_LAST) ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    wait_d = state_d == PAUSE || state_d == SETTLE || state_d == FETCH;
    req_d  = osd_status & ~osd_q & autosave & (state_q == IDLE);
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      oor_q       <= 1'b0;
      end_q       <= 1'b0;
      din_q       <= '0;
      ram_addr_q  <= '0;
      osd_q       <= 1'b0;
      wait_q      <= 1'b0;
      req_q       <= 1'b0;
      pause_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      oor_q       <= oor_d;
      end_q       <= end_d;
      din_q       <= din_d;
      ram_addr_q  <= ram_addr_d;
      osd_q       <= osd_status;
      wait_q      <= wait_d;
      req_q       <= req_d;
      pause_q     <= state_d != IDLE;
      busy_q      <= state_d != IDLE;
    end
  end
  assign io.ioctl_din        = din_q;
  assign io.ioctl_wait       = wait_q;
  assign io.ioctl_upload_req = req_q;
  assign pause_cpu           = pause_q;
  assign busy                = busy_q;
  assign ram_addr            = ram_addr_q;
endmodule

// File: tb/tb_nvram_upload_ctrl.sv
// tb_nvram_upload_ctrl: vector table, hand sequences and random reads against an address-rule model
module tb_nvram_upload_ctrl;
  localparam int DW = 10;
  typedef struct { logic [24:0] addr; logic [7:0] din; } vec_t;
  logic          clk_sys = 1'b0, reset = 1'b1;
  logic          osd_status = 1'b0, autosave = 1'b0, paused = 1'b0;
  logic          pause_cpu, busy;
  logic [DW-1:0] ram_addr;
  logic [7:0]    ram_data = 8'h00;
  logic [7:0]    mem [1024];
  logic [DW-1:0] last_addr = '0;
  int            checks = 0, errors = 0;
  vec_t          vecs [8];
  nvram_upload_ctrl_if bus();
  nvram_upload_ctrl #(.DUMPWIDTH(DW), .DUMPINDEX(4), .READ_LAT(2), .PAUSEPAD(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .io(bus), .osd_status(osd_status), .autosave(autosave),
    .paused(paused), .pause_cpu(pause_cpu), .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy)
  );
  always #5 clk_sys = ~clk_sys;
  // Dump port with two cycles from address edge to capture edge
  always @(posedge clk_sys) ram_data <= mem[ram_addr];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] model(input logic [24:0] a);
    return (a < 25'd1024) ? (8'(a) ^ 8'h5A) : 8'h00;
  endfunction
  task automatic chk_reset(input string tag);
    chk({tag, "_din"},   32'(bus.ioctl_din), 0);
    chk({tag, "_wait"},  32'(bus.ioctl_wait), 0);
    chk({tag, "_req"},   32'(bus.ioctl_upload_req), 0);
    chk({tag, "_pause"}, 32'(pause_cpu), 0);
    chk({tag, "_raddr"}, 32'(ram_addr), 0);
    chk({tag, "_busy"},  32'(busy), 0);
  endtask
  task automatic start_upload();
    bus.ioctl_index = 8'd4;
    bus.ioctl_upload = 1'b1;
    step();
    chk("start_pause", 32'(pause_cpu), 1);
    chk("start_wait", 32'(bus.ioctl_wait), 1);
    chk("start_busy", 32'(busy), 1);
    repeat (5) step();
    paused = 1'b1;
    step();
    chk("settle_wait1", 32'(bus.ioctl_wait), 1);
    step();
    chk("settle_wait2", 32'(bus.ioctl_wait), 1);
    step();
    chk("ready_wait", 32'(bus.ioctl_wait), 0);
  endtask
  task automatic do_read(input logic [24:0] a, input logic [7:0] exp);
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = a;
    step();
    bus.ioctl_rd = 1'b0;
    if (a < 25'd1024) last_addr = a[DW-1:0];
    chk("rd_wait1", 32'(bus.ioctl_wait), 1);
    chk("rd_ram_addr", 32'(ram_addr), 32'(last_addr));
    step();
    chk("rd_wait2", 32'(bus.ioctl_wait), 1);
    step();
    chk("rd_wait_low", 32'(bus.ioctl_wait), 0);
    chk("rd_din", 32'(bus.ioctl_din), 32'(exp));
  endtask
  initial begin
    logic [24:0] a;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    vecs[0] = '{25'd0,        8'h5A};
    vecs[1] = '{25'd1,        8'h5B};
    vecs[2] = '{25'h055,      8'h0F};
    vecs[3] = '{25'h2A5,      8'hFF};
    vecs[4] = '{25'd1023,     8'hA5};
    vecs[5] = '{25'd1024,     8'h00};
    vecs[6] = '{25'd512,      8'h5A};
    vecs[7] = '{25'h1FFFFFF,  8'h00};
    bus.ioctl_upload = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0;
    repeat (3) step();
    reset = 1'b0;
    chk_reset("reset");
    bus.ioctl_index = 8'd3;
    bus.ioctl_upload = 1'b1;
    repeat (4) begin
      step();
      chk("idx3_pause", 32'(pause_cpu), 0);
      chk("idx3_wait", 32'(bus.ioctl_wait), 0);
      chk("idx3_busy", 32'(busy), 0);
    end
    bus.ioctl_upload = 1'b0;
    step();
    autosave = 1'b1;
    osd_status = 1'b1;
    step();
    chk("as_pulse", 32'(bus.ioctl_upload_req), 1);
    step();
    chk("as_pulse_end", 32'(bus.ioctl_upload_req), 0);
    osd_status = 1'b0;
    step();
    chk("as_fall", 32'(bus.ioctl_upload_req), 0);
    step();
    autosave = 1'b0;
    osd_status = 1'b1;
    step();
    chk("as_disabled", 32'(bus.ioctl_upload_req), 0);
    osd_status = 1'b0;
    autosave = 1'b1;
    step();
    start_upload();
    osd_status = 1'b1;
    step();
    chk("as_busy", 32'(bus.ioctl_upload_req), 0);
    step();
    chk("as_busy2", 32'(bus.ioctl_upload_req), 0);
    osd_status = 1'b0;
    foreach (vecs[i]) do_read(vecs[i].addr, vecs[i].din);
    for (int i = 0; i < 1024; i++) do_read(25'(i), model(25'(i)));
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 25'($urandom()) : 25'($urandom_range(0, 1100));
      repeat ($urandom_range(0, 3)) step();
      do_read(a, model(a));
    end
    bus.ioctl_upload = 1'b0;
    step();
    chk("end_pause1", 32'(pause_cpu), 1);
    chk("end_busy1", 32'(busy), 1);
    step();
    chk("end_pause2", 32'(pause_cpu), 1);
    step();
    chk("end_pause_low", 32'(pause_cpu), 0);
    chk("end_busy_low", 32'(busy), 0);
    paused = 1'b0;
    step();
    start_upload();
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 25'd10;
    step();
    bus.ioctl_rd = 1'b0;
    chk("fetch_wait", 32'(bus.ioctl_wait), 1);
    reset = 1'b1;
    bus.ioctl_upload = 1'b0;
    step();
    chk_reset("midreset");
    reset = 1'b0;
    paused = 1'b0;
    last_addr = '0;
    step();
    chk("postreset_pause", 32'(pause_cpu), 0);
    bus.ioctl_index = 8'd4;
    bus.ioctl_upload = 1'b1;
    step();
    chk("pend_start_pause", 32'(pause_cpu), 1);
    repeat (2) step();
    paused = 1'b1;
    step();
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 25'd7;
    step();
    bus.ioctl_rd = 1'b0;
    for (int i = 0; i < 20 && bus.ioctl_din !== 8'h5D; i++) step();
    chk("pend_din", 32'(bus.ioctl_din), 32'h5D);
    chk("pend_wait", 32'(bus.ioctl_wait), 0);
    chk("pend_raddr", 32'(ram_addr), 7);
    last_addr = 10'd7;
    do_read(25'd10, 8'h50);
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 25'd100;
    step();
    bus.ioctl_rd = 1'b0;
    step();
    bus.ioctl_upload = 1'b0;
    step();
    chk("midfetch_din", 32'(bus.ioctl_din), 32'h3E);
    chk("midfetch_wait", 32'(bus.ioctl_wait), 0);
    chk("midfetch_pause1", 32'(pause_cpu), 1);
    step();
    chk("midfetch_pause2", 32'(pause_cpu), 1);
    step();
    chk("midfetch_pause_low", 32'(pause_cpu), 0);
    chk("midfetch_busy_low", 32'(busy), 0);
    paused = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
